binary_div_14_7_seq: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse of the team's 7x7 registered array multiplier.
- Takes a 14-bit dividend (the product width) and a 7-bit divisor, and returns a 14-bit quotient and a 7-bit remainder.
- Iterates one quotient bit per enabled clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath, e.g. to recover an operand from a product or for general scaling.

---
 rtl/binary_div_14_7_seq.sv | 97 +++++++++
 tb/tb_binary_div_14_7_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_div_14_7_seq.sv
// binary_div_14_7_seq: sequential unsigned restoring divider, one quotient bit per enabled clock
module binary_div_14_7_seq #(
    parameter int N_W = 14,
    parameter int D_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic           div_zero,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder
);
    localparam int C_W = $clog2(N_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DZ, DONE} state_t;

    state_t         state, state_nxt;
    logic [C_W-1:0] cnt;
    logic [N_W-1:0] dvd;
    logic [D_W-1:0] dvs;
    logic [D_W:0]   rem;
    logic [D_W+1:0] ext, trial;
    logic [D_W:0]   rem_nxt;
    logic           ge, accept;

    // Trial subtraction: one extra bit above the shifted remainder so the borrow is visible
    always_comb begin
        ext     = {rem, dvd[N_W-1]};
        trial   = ext - {2'b00, dvs};
        ge      = !trial[D_W+1];
        rem_nxt = ge ? trial[D_W:0] : ext[D_W:0];
        accept  = start && (state == IDLE || state == DONE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    // Next-state logic; a zero divisor takes the short DZ path instead of iterating
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = start ? (divisor != '0 ? CALC : DZ) : IDLE;
            CALC:       state_nxt = (cnt == C_W'(1)) ? DONE : CALC;
            DZ:         state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so done stretches whenever en holds the state
    always_comb begin
        busy = (state == CALC) || (state == DZ);
        done = (state == DONE);
    end

    // Datapath: capture operands, shift in quotient bits, publish results on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (en) begin
            if (accept) begin
                dvd <= dividend;
                dvs <= divisor;
                cnt <= C_W'(N_W);
                rem <= '0;
            end else if (state == CALC) begin
                dvd <= {dvd[N_W-2:0], ge};
                rem <= rem_nxt;
                cnt <= cnt - C_W'(1);
                if (cnt == C_W'(1)) begin
                    quotient  <= {dvd[N_W-2:0], ge};
                    remainder <= rem_nxt[D_W-1:0];
                    div_zero  <= 1'b0;
                end
            end else if (state == DZ) begin
                quotient  <= '1;
                remainder <= '1;
                div_zero  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_binary_div_14_7_seq.sv
// tb_binary_div_14_7_seq: scoreboard bench for the sequential 14/7 divider
module tb_binary_div_14_7_seq;
    typedef struct packed {
        logic [13:0] q;
        logic [6:0]  r;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, start;
    logic [13:0] dividend;
    logic [6:0]  divisor;
    logic        busy, done, div_zero;
    logic [13:0] quotient;
    logic [6:0]  remainder;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    binary_div_14_7_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // Drive one accepted-start edge, record the expectation, then scramble the operand inputs
    task automatic issue(input logic [13:0] a, input logic [6:0] b,
                         input logic [13:0] q, input logic [6:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        dividend = a; divisor = b; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        dividend = 14'($urandom);
        divisor = 7'($urandom);
    endtask

    // Bounded wait for done; n counts edges since the accepting edge
    task automatic wait_done(inout int n);
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, div_zero, quotient, remainder} !== 24'd0) begin
            fails++;
            $display("FAIL reset: got busy=%b done=%b dz=%b q=%0d r=%0d, want all 0", busy, done, div_zero, quotient, remainder);
        end
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n = 0;
        exp_t e;
        issue(14'd5000, 7'd70, 14'd71, 7'd30, 1'b0);
        tests++;
        if ({busy, done} !== 2'b10) begin
            fails++;
            $display("FAIL basic_busy: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL basic: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        @(negedge clk);
        tests++;
        if ({done, busy, quotient, remainder} !== {2'b00, 14'd71, 7'd30}) begin
            fails++;
            $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want done=0 busy=0 q=71 r=30", done, busy, quotient, remainder);
        end
    endtask

    task automatic test_extremes;
        int n;
        exp_t e;
        issue(14'd16383, 7'd127, 14'd129, 7'd0, 1'b0);
        n = 0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL max_by_max: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        issue(14'd16383, 7'd1, 14'd16383, 7'd0, 1'b0);
        n = 0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL max_by_one: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_small_and_zero;
        int n;
        exp_t e;
        issue(14'd5, 7'd100, 14'd0, 7'd5, 1'b0);
        n = 0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL small: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        issue(14'd9, 7'd0, 14'h3FFF, 7'h7F, 1'b1);
        n = 0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd1, e}) begin
            fails++;
            $display("FAIL div_zero: got done=%b lat=%0d q=%h r=%h dz=%b, want done=1 lat=1 q=%h r=%h dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        @(negedge clk);
        tests++;
        if ({done, busy, div_zero} !== 3'b001) begin
            fails++;
            $display("FAIL div_zero_hold: got done=%b busy=%b dz=%b, want done=0 busy=0 dz=1", done, busy, div_zero);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        exp_t e;
        issue(14'd1000, 7'd9, 14'd111, 7'd1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        dividend = 14'd50; divisor = 7'd5; start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL ignore_start: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        issue(14'd50, 7'd5, 14'd10, 7'd0, 1'b0);
        tests++;
        if ({done, busy} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
        n = 0;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL b2b: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_enable_stall;
        int n = 0;
        exp_t e;
        issue(14'd4970, 7'd71, 14'd70, 7'd0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if ({busy, done} !== 2'b10) begin
            fails++;
            $display("FAIL stall_hold: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        en = 1'b1;
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd20, e}) begin
            fails++;
            $display("FAIL stall: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=20 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({done, quotient} !== {1'b1, 14'd70}) begin
            fails++;
            $display("FAIL done_stretch: got done=%b q=%0d, want done=1 q=70", done, quotient);
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_release: got done=%b, want 0", done);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        exp_t e;
        issue(14'd5000, 7'd70, 14'd71, 7'd30, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        tests++;
        if ({busy, done, div_zero, quotient, remainder} !== 24'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%0d r=%0d, want all 0", busy, done, div_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(14'd200, 7'd7, 14'd28, 7'd4, 1'b0);
        wait_done(n);
        e = sb.pop_front();
        tests++;
        if ({done, n[7:0], quotient, remainder, div_zero} !== {1'b1, 8'd14, e}) begin
            fails++;
            $display("FAIL after_reset: got done=%b lat=%0d q=%0d r=%0d dz=%b, want done=1 lat=14 q=%0d r=%0d dz=%b", done, n, quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_small_and_zero;
        test_back_to_back;
        test_enable_stall;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
